mult_wb_sched: RTL and testbench

Issue and write-back scheduler for the pipelined multiplier manager. It decides in ID whether a multiply may issue, and tracks destination registers of outstanding multiplies in a scoreboard. It stalls RAW/WAW-dependent instructions. It shares the single register-file write port between the main pipeline write-back and multiplier results. Multiplier results cannot be back-pressured, so they go through a small FIFO, and issue credits guarantee the FIFO never overflows.

---
 rtl/mult_wb_sched_pkg.sv | 33 +++
 rtl/mult_wb_sched_if.sv | 42 ++++
 rtl/mult_wb_fifo.sv | 81 ++++++++
 rtl/mult_wb_sched.sv | 128 ++++++++++++
 tb/tb_mult_wb_sched.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_wb_sched_pkg.sv
// Shared types and constants for the multiply issue / write-back scheduler.
package mult_wb_sched_pkg;

  // Result FIFO depth; also the number of multiplies with rd!=0 allowed in flight.
  localparam int MULT_WB_BUF_DEPTH = 2;

  // Pipeline stages inside the multiplier manager; a grant in cycle t
  // produces a result at the manager output in cycle t+1+MULT_PPL_STAGE.
  localparam int MULT_PPL_STAGE = 2;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  // One pending register-file write: 5-bit address above 32-bit data.
  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  // Which source owns the single register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_FIFO,
    SRC_BYPASS
  } port_src_e;

  // x0 is never tracked, never buffered and never counted against credits.
  function automatic logic is_real_reg(reg_addr_t a);
    return a != 5'd0;
  endfunction

endpackage

// File: rtl/mult_wb_sched_if.sv
// ID / multiplier / write-back / register-file signals of the scheduler.
interface mult_wb_sched_if;
  import mult_wb_sched_pkg::*;

  logic      id_valid_i;
  logic      id_mult_req_i;
  logic      id_rs1_used_i;
  logic      id_rs2_used_i;
  reg_addr_t id_rs1_addr_i;
  reg_addr_t id_rs2_addr_i;
  logic      id_wb_en_i;
  reg_addr_t id_rd_addr_i;
  logic      ex_hold_i;
  logic      stall_o;
  logic      mult_use_o;
  reg_addr_t mult_rd_addr_i;
  reg_data_t mult_rd_data_i;
  logic      wb_we_i;
  reg_addr_t wb_addr_i;
  reg_data_t wb_data_i;
  logic      rf_we_o;
  reg_addr_t rf_waddr_o;
  reg_data_t rf_wdata_o;
  logic [31:0] pend_flags_o;

  // Pipeline side: drives ID, manager and write-back, observes grants and the port.
  modport master (
    output id_valid_i, id_mult_req_i, id_rs1_used_i, id_rs2_used_i,
    output id_rs1_addr_i, id_rs2_addr_i, id_wb_en_i, id_rd_addr_i, ex_hold_i,
    output mult_rd_addr_i, mult_rd_data_i, wb_we_i, wb_addr_i, wb_data_i,
    input  stall_o, mult_use_o, rf_we_o, rf_waddr_o, rf_wdata_o, pend_flags_o
  );

  // Scheduler side.
  modport slave (
    input  id_valid_i, id_mult_req_i, id_rs1_used_i, id_rs2_used_i,
    input  id_rs1_addr_i, id_rs2_addr_i, id_wb_en_i, id_rd_addr_i, ex_hold_i,
    input  mult_rd_addr_i, mult_rd_data_i, wb_we_i, wb_addr_i, wb_data_i,
    output stall_o, mult_use_o, rf_we_o, rf_waddr_o, rf_wdata_o, pend_flags_o
  );

endinterface

// File: rtl/mult_wb_fifo.sv
// Small synchronous FIFO holding multiplier results that lost the write port.
// Pointers carry an index plus a wrap bit so full and empty are distinguishable.
module mult_wb_fifo
  import mult_wb_sched_pkg::*;
#(
  parameter int DEPTH = MULT_WB_BUF_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             wr_wrap_q, wr_wrap_d;
  logic             rd_wrap_q, rd_wrap_d;

  // Status flags and head entry straight from the registered pointers.
  always_comb begin
    empty_o = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
    full_o  = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
    head_o  = mem_q[rd_idx_q];
  end

  // Next storage and pointers; push and pop are independent, so both may happen at once.
  always_comb begin
    mem_d     = mem_q;
    wr_idx_d  = wr_idx_q;
    wr_wrap_d = wr_wrap_q;
    rd_idx_d  = rd_idx_q;
    rd_wrap_d = rd_wrap_q;
    if (push_i) begin
      mem_d[wr_idx_q] = push_data_i;
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_wrap_d = ~wr_wrap_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (pop_i) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d  = '0;
        rd_wrap_d = ~rd_wrap_q;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  // Register storage and pointers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_wrap_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_idx_q  <= wr_idx_d;
      wr_wrap_q <= wr_wrap_d;
      rd_idx_q  <= rd_idx_d;
      rd_wrap_q <= rd_wrap_d;
    end
  end

  // The issue credits upstream make a push into a full queue (without a pop) impossible.
  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/mult_wb_sched.sv
// Multiply issue and write-back scheduler: scoreboard of outstanding multiply
// destinations, issue credits bounding results in flight, RAW/WAW/credit stall,
// and arbitration of the single register-file write port.
module mult_wb_sched
  import mult_wb_sched_pkg::*;
#(
  parameter int BUF_DEPTH = MULT_WB_BUF_DEPTH
) (
  input logic           clk,
  input logic           rst,
  mult_wb_sched_if.slave bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] outst_q, outst_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t  fifo_head, arrival;
  logic       arr_valid;
  logic       hazard, credit_stall, stall, grant, grant_rd;
  logic       mult_commit;
  reg_addr_t  commit_addr;
  port_src_e  port_src;

  assign arrival   = {bus.mult_rd_addr_i, bus.mult_rd_data_i};
  assign arr_valid = is_real_reg(bus.mult_rd_addr_i);

  mult_wb_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_data_i(arrival),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Hazard and credit stalls, and the resulting multiply grant at ID.
  always_comb begin
    hazard = bus.id_valid_i &
             ((bus.id_rs1_used_i & pend_q[bus.id_rs1_addr_i]) |
              (bus.id_rs2_used_i & pend_q[bus.id_rs2_addr_i]) |
              (bus.id_wb_en_i    & pend_q[bus.id_rd_addr_i]));
    credit_stall = bus.id_valid_i & bus.id_mult_req_i &
                   is_real_reg(bus.id_rd_addr_i) & (outst_q == CNT_MAX);
    stall    = hazard | credit_stall;
    grant    = bus.id_valid_i & bus.id_mult_req_i & ~stall & ~bus.ex_hold_i;
    grant_rd = grant & is_real_reg(bus.id_rd_addr_i);
  end

  // Write-port owner: main write-back first, then the oldest buffered result, then a bypass.
  always_comb begin
    port_src = SRC_NONE;
    if (bus.wb_we_i) begin
      port_src = SRC_WB;
    end else if (!fifo_empty) begin
      port_src = SRC_FIFO;
    end else if (arr_valid) begin
      port_src = SRC_BYPASS;
    end
    fifo_pop    = (port_src == SRC_FIFO);
    fifo_push   = arr_valid & (~fifo_empty | bus.wb_we_i);
    mult_commit = (port_src == SRC_FIFO) | (port_src == SRC_BYPASS);
    commit_addr = fifo_pop ? fifo_head.addr : arrival.addr;
  end

  // Register-file port mux and status outputs.
  always_comb begin
    bus.rf_we_o    = 1'b0;
    bus.rf_waddr_o = '0;
    bus.rf_wdata_o = '0;
    case (port_src)
      SRC_WB: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = bus.wb_addr_i;
        bus.rf_wdata_o = bus.wb_data_i;
      end
      SRC_FIFO: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = fifo_head.addr;
        bus.rf_wdata_o = fifo_head.data;
      end
      SRC_BYPASS: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = arrival.addr;
        bus.rf_wdata_o = arrival.data;
      end
      default: begin
        bus.rf_we_o = 1'b0;
      end
    endcase
    bus.stall_o      = stall;
    bus.mult_use_o   = grant;
    bus.pend_flags_o = pend_q;
  end

  // Scoreboard and credit update; grant and commit never share an rd thanks to the WAW stall.
  always_comb begin
    pend_d = pend_q;
    if (mult_commit) pend_d[commit_addr] = 1'b0;
    if (grant_rd) pend_d[bus.id_rd_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
    outst_d = outst_q;
    case ({grant_rd, mult_commit})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Scoreboard and credit registers; reset forgets every outstanding multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      outst_q <= '0;
    end else begin
      pend_q  <= pend_d;
      outst_q <= outst_d;
    end
  end

endmodule

// File: tb/tb_mult_wb_sched.sv
// Directed bench for mult_wb_sched with a simple latency model of the multiplier manager.
module tb_mult_wb_sched;
  import mult_wb_sched_pkg::*;

  localparam int LAT = 1 + MULT_PPL_STAGE;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mult_wb_sched_if bus ();

  mult_wb_sched #(
    .BUF_DEPTH(MULT_WB_BUF_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Manager model: a granted multiply appears LAT cycles later with data C0DE_00rd.
  wb_entry_t mgr_pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) mgr_pipe[k] <= '0;
    end else begin
      mgr_pipe[0] <= bus.mult_use_o ?
                     {bus.id_rd_addr_i, 32'hC0DE_0000 | {27'd0, bus.id_rd_addr_i}} : '0;
      for (int k = 1; k < LAT; k++) mgr_pipe[k] <= mgr_pipe[k-1];
    end
  end
  assign bus.mult_rd_addr_i = mgr_pipe[LAT-1].addr;
  assign bus.mult_rd_data_i = mgr_pipe[LAT-1].data;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic setInputs(input logic v, input logic m, input reg_addr_t rs1,
                           input reg_addr_t rs2, input reg_addr_t rd, input logic hold,
                           input logic we, input reg_addr_t wa, input reg_data_t wd);
    bus.id_valid_i    = v;
    bus.id_mult_req_i = m;
    bus.id_rs1_used_i = v & (rs1 != 5'd0);
    bus.id_rs2_used_i = v & (rs2 != 5'd0);
    bus.id_rs1_addr_i = rs1;
    bus.id_rs2_addr_i = rs2;
    bus.id_wb_en_i    = v;
    bus.id_rd_addr_i  = rd;
    bus.ex_hold_i     = hold;
    bus.wb_we_i       = we;
    bus.wb_addr_i     = wa;
    bus.wb_data_i     = wd;
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge for checks.
  task automatic applyStimulus(input logic v, input logic m, input reg_addr_t rs1,
                               input reg_addr_t rs2, input reg_addr_t rd, input logic hold,
                               input logic we, input reg_addr_t wa, input reg_data_t wd);
    @(posedge clk);
    #1;
    setInputs(v, m, rs1, rs2, rd, hold, we, wa, wd);
    @(negedge clk);
  endtask

  task automatic cycIdle();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic cycMul(input reg_addr_t rd, input logic we, input reg_addr_t wa,
                        input reg_data_t wd);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, rd, 1'b0, we, wa, wd);
  endtask

  task automatic cycAlu(input reg_addr_t rs1, input reg_addr_t rd);
    applyStimulus(1'b1, 1'b0, rs1, 5'd0, rd, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic cycWb(input reg_addr_t wa, input reg_data_t wd);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, wa, wd);
  endtask

  // Reset cycle with idle inputs, then one idle cycle out of reset ready for checks.
  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    setInputs(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkPort(input string tag, input logic we, input reg_addr_t wa,
                           input reg_data_t wd);
    checkBit({tag, "_we"}, bus.rf_we_o, we);
    checkOutput({tag, "_waddr"}, {27'd0, bus.rf_waddr_o}, {27'd0, wa});
    checkOutput({tag, "_wdata"}, bus.rf_wdata_o, wd);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    setInputs(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    $display("[TB] directed sequence, manager latency %0d", LAT);

    pulseReset();
    checkPort("reset_port", 1'b0, 5'd0, 32'd0);
    checkBit("reset_stall", bus.stall_o, 1'b0);
    checkBit("reset_use", bus.mult_use_o, 1'b0);
    checkOutput("reset_pend", bus.pend_flags_o, 32'd0);

    // Single multiply to x5 with the port idle.
    cycMul(5'd5, 1'b0, 5'd0, 32'd0);
    checkBit("single_use", bus.mult_use_o, 1'b1);
    checkBit("single_stall", bus.stall_o, 1'b0);
    checkOutput("single_pend_grant", bus.pend_flags_o, 32'd0);
    for (int i = 0; i < MULT_PPL_STAGE; i++) begin
      cycIdle();
      checkOutput("single_pend_wait", bus.pend_flags_o, 32'h0000_0020);
      checkBit("single_we_wait", bus.rf_we_o, 1'b0);
    end
    cycIdle();
    checkPort("single_commit", 1'b1, 5'd5, 32'hC0DE_0005);
    checkOutput("single_pend_commit", bus.pend_flags_o, 32'h0000_0020);
    cycIdle();
    checkOutput("single_pend_after", bus.pend_flags_o, 32'd0);
    checkBit("single_we_after", bus.rf_we_o, 1'b0);

    // RAW: multiply to x7, then an add reading x7.
    cycMul(5'd7, 1'b0, 5'd0, 32'd0);
    checkBit("raw_use", bus.mult_use_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycAlu(5'd7, 5'd8);
      checkBit("raw_stall", bus.stall_o, 1'b1);
      checkBit("raw_no_use", bus.mult_use_o, 1'b0);
    end
    cycAlu(5'd7, 5'd8);
    checkBit("raw_stall_commit", bus.stall_o, 1'b1);
    checkPort("raw_commit", 1'b1, 5'd7, 32'hC0DE_0007);
    cycAlu(5'd7, 5'd8);
    checkBit("raw_release", bus.stall_o, 1'b0);
    checkOutput("raw_pend", bus.pend_flags_o, 32'd0);

    // WAW: multiply to x7, then an add writing x7.
    cycMul(5'd7, 1'b0, 5'd0, 32'd0);
    checkBit("waw_use", bus.mult_use_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycAlu(5'd0, 5'd7);
      checkBit("waw_stall", bus.stall_o, 1'b1);
    end
    checkPort("waw_commit", 1'b1, 5'd7, 32'hC0DE_0007);
    cycAlu(5'd0, 5'd7);
    checkBit("waw_release", bus.stall_o, 1'b0);

    // Port contention: x3 result arrives while write-back writes x9.
    cycMul(5'd3, 1'b0, 5'd0, 32'd0);
    cycIdle();
    cycIdle();
    cycWb(5'd9, 32'h1234_5678);
    checkPort("cont_wb", 1'b1, 5'd9, 32'h1234_5678);
    checkOutput("cont_pend_wb", bus.pend_flags_o, 32'h0000_0008);
    cycIdle();
    checkPort("cont_fifo", 1'b1, 5'd3, 32'hC0DE_0003);
    checkOutput("cont_pend_fifo", bus.pend_flags_o, 32'h0000_0008);
    cycIdle();
    checkBit("cont_idle_we", bus.rf_we_o, 1'b0);
    checkOutput("cont_pend_after", bus.pend_flags_o, 32'd0);
    cycWb(5'd0, 32'hDEAD_BEEF);
    checkPort("x0_forward", 1'b1, 5'd0, 32'hDEAD_BEEF);

    // Credit exhaustion: x1, x2, x3 back to back with write-back holding the port.
    cycMul(5'd1, 1'b1, 5'd20, 32'h5555_0014);
    checkBit("cred_use1", bus.mult_use_o, 1'b1);
    cycMul(5'd2, 1'b1, 5'd20, 32'h5555_0014);
    checkBit("cred_use2", bus.mult_use_o, 1'b1);
    cycMul(5'd3, 1'b1, 5'd20, 32'h5555_0014);
    checkBit("cred_stall_c2", bus.stall_o, 1'b1);
    checkBit("cred_no_use_c2", bus.mult_use_o, 1'b0);
    checkOutput("cred_pend_c2", bus.pend_flags_o, 32'h0000_0006);
    cycMul(5'd3, 1'b1, 5'd20, 32'h5555_0014);
    checkBit("cred_stall_c3", bus.stall_o, 1'b1);
    checkPort("cred_wb_c3", 1'b1, 5'd20, 32'h5555_0014);
    cycMul(5'd3, 1'b1, 5'd20, 32'h5555_0014);
    checkBit("cred_stall_c4", bus.stall_o, 1'b1);
    checkPort("cred_wb_c4", 1'b1, 5'd20, 32'h5555_0014);
    cycMul(5'd3, 1'b0, 5'd0, 32'd0);
    checkBit("cred_stall_c5", bus.stall_o, 1'b1);
    checkPort("cred_x1", 1'b1, 5'd1, 32'hC0DE_0001);
    cycMul(5'd3, 1'b0, 5'd0, 32'd0);
    checkBit("cred_stall_c6", bus.stall_o, 1'b0);
    checkBit("cred_use3", bus.mult_use_o, 1'b1);
    checkPort("cred_x2", 1'b1, 5'd2, 32'hC0DE_0002);
    checkOutput("cred_pend_c6", bus.pend_flags_o, 32'h0000_0004);
    cycIdle();
    checkBit("cred_we_c7", bus.rf_we_o, 1'b0);
    checkOutput("cred_pend_c7", bus.pend_flags_o, 32'h0000_0008);
    cycIdle();
    cycIdle();
    checkPort("cred_x3", 1'b1, 5'd3, 32'hC0DE_0003);
    cycIdle();
    checkOutput("cred_pend_end", bus.pend_flags_o, 32'd0);

    // Ordering: x10, x11 buffered, x12 arrives as x11 leaves (push and pop together).
    cycMul(5'd10, 1'b0, 5'd0, 32'd0);
    cycMul(5'd11, 1'b0, 5'd0, 32'd0);
    cycIdle();
    cycWb(5'd21, 32'h7777_0015);
    cycWb(5'd21, 32'h7777_0015);
    cycMul(5'd12, 1'b0, 5'd0, 32'd0);
    checkBit("ord_stall_c5", bus.stall_o, 1'b1);
    checkOutput("ord_pend_c5", bus.pend_flags_o, 32'h0000_0C00);
    checkPort("ord_x10", 1'b1, 5'd10, 32'hC0DE_000A);
    cycMul(5'd12, 1'b1, 5'd21, 32'h7777_0015);
    checkBit("ord_use_c6", bus.mult_use_o, 1'b1);
    checkPort("ord_wb_c6", 1'b1, 5'd21, 32'h7777_0015);
    cycWb(5'd21, 32'h7777_0015);
    cycWb(5'd21, 32'h7777_0015);
    cycIdle();
    checkPort("ord_x11", 1'b1, 5'd11, 32'hC0DE_000B);
    checkOutput("ord_pend_c9", bus.pend_flags_o, 32'h0000_1800);
    cycIdle();
    checkPort("ord_x12", 1'b1, 5'd12, 32'hC0DE_000C);
    cycIdle();
    checkBit("ord_we_end", bus.rf_we_o, 1'b0);
    checkOutput("ord_pend_end", bus.pend_flags_o, 32'd0);

    // Reset with two multiplies outstanding.
    cycMul(5'd13, 1'b0, 5'd0, 32'd0);
    cycMul(5'd14, 1'b0, 5'd0, 32'd0);
    checkBit("rst_use14", bus.mult_use_o, 1'b1);
    pulseReset();
    checkPort("rst_port", 1'b0, 5'd0, 32'd0);
    checkBit("rst_stall", bus.stall_o, 1'b0);
    checkBit("rst_use", bus.mult_use_o, 1'b0);
    checkOutput("rst_pend", bus.pend_flags_o, 32'd0);
    cycMul(5'd15, 1'b0, 5'd0, 32'd0);
    checkBit("rst_reissue", bus.mult_use_o, 1'b1);
    checkBit("rst_reissue_stall", bus.stall_o, 1'b0);
    checkBit("rst_no_stale", bus.rf_we_o, 1'b0);
    cycIdle();
    cycIdle();
    cycIdle();
    checkPort("rst_x15", 1'b1, 5'd15, 32'hC0DE_000F);

    // rd=0 multiply bypasses credits; ex_hold blocks a grant without stalling.
    cycMul(5'd17, 1'b0, 5'd0, 32'd0);
    cycMul(5'd18, 1'b0, 5'd0, 32'd0);
    cycMul(5'd0, 1'b0, 5'd0, 32'd0);
    checkBit("rd0_use_full", bus.mult_use_o, 1'b1);
    checkBit("rd0_stall_full", bus.stall_o, 1'b0);
    checkOutput("rd0_pend", bus.pend_flags_o, 32'h0006_0000);
    cycIdle();
    checkPort("rd0_x17", 1'b1, 5'd17, 32'hC0DE_0011);
    cycIdle();
    checkPort("rd0_x18", 1'b1, 5'd18, 32'hC0DE_0012);
    cycIdle();
    checkBit("rd0_no_result", bus.rf_we_o, 1'b0);
    checkOutput("rd0_pend_end", bus.pend_flags_o, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 5'd0, 32'd0);
    checkBit("hold_no_use", bus.mult_use_o, 1'b0);
    checkBit("hold_no_stall", bus.stall_o, 1'b0);
    cycIdle();
    checkOutput("hold_pend", bus.pend_flags_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
